// File: rtl/fetch_queue.sv
// fetch_queue: IF->ID instruction buffer of {pc, instruction} pairs.
// Fetch can run ahead while ID stalls; a taken branch (flush) drops everything.
module fetch_queue #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] instruction_in,
  input  logic             pop_ready,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] instruction_out,
  output logic [CW-1:0]    count,
  output logic             almost_full
);

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  // Ready/valid come from the registered count only, so pop_ready never
  // reaches push_ready combinationally; a full queue refuses a push even
  // when the head is popped in the same cycle.
  assign push_ready  = (count != CW'(DEPTH));
  assign pop_valid   = (count != '0);
  assign almost_full = (count >= CW'(DEPTH - 1));

  assign do_push = push_valid & push_ready & ~flush;
  assign do_pop  = pop_ready  & pop_valid  & ~flush;

  // Empty queue presents an all-zero word to ID rather than stale storage.
  assign head            = mem[rd_ptr];
  assign pc_out          = pop_valid ? head.pc    : '0;
  assign instruction_out = pop_valid ? head.instr : '0;

  // Pointer/occupancy state; reset and flush both discard every entry.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents are left as-is on reset/flush since the
  // output gating and pointers make old entries unreachable.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= '{pc: pc_in, instr: instruction_in};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based reference model of the fetch queue.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0, flush = 1'b0, push_valid = 1'b0, pop_ready = 1'b0;
  logic [WIDTH-1:0] pc_in = '0, instruction_in = '0;
  logic             push_ready, pop_valid, almost_full;
  logic [WIDTH-1:0] pc_out, instruction_out;
  logic [CW-1:0]    count;

  int checks = 0;
  int errors = 0;

  // reference model: FIFO of {pc, instruction}
  logic [2*WIDTH-1:0] q[$];

  fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready),
    .pc_in(pc_in), .instruction_in(instruction_in),
    .pop_ready(pop_ready), .pop_valid(pop_valid),
    .pc_out(pc_out), .instruction_out(instruction_out),
    .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the model's view of the queue.
  task automatic check_all();
    int n = q.size();
    chk("count",       64'(count),          64'(n));
    chk("push_ready",  64'(push_ready),     64'(n < DEPTH));
    chk("pop_valid",   64'(pop_valid),      64'(n != 0));
    chk("almost_full", 64'(almost_full),    64'(n >= DEPTH - 1));
    chk("pc_out",      64'(pc_out),         n ? 64'(q[0][2*WIDTH-1:WIDTH]) : 64'd0);
    chk("instr_out",   64'(instruction_out), n ? 64'(q[0][WIDTH-1:0]) : 64'd0);
  endtask

  // One clock: apply inputs, advance the model at the edge, check after it.
  task automatic cyc(input logic r, input logic f, input logic pv,
                     input logic [WIDTH-1:0] pc, input logic [WIDTH-1:0] ins,
                     input logic pr);
    bit pok, dok;
    rst = r; flush = f; push_valid = pv; pc_in = pc; instruction_in = ins; pop_ready = pr;
    @(posedge clk);
    if (r || f) q.delete();
    else begin
      pok = pv && (q.size() < DEPTH);
      dok = pr && (q.size() > 0);
      if (dok) void'(q.pop_front());
      if (pok) q.push_back({pc, ins});
    end
    #1;
    check_all();
  endtask

  initial begin
    // 1: reset
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_count", 64'(count), 64'd0);

    // 2: fill with pop stalled, then a refused 5th push
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 32'(4*i), 32'hE3A00014 + 32'(i), 0);
    chk("full_ready", 64'(push_ready), 64'd0);
    cyc(0, 0, 1, 32'd16, 32'hE3A00018, 0);
    chk("full_refuse", 64'(count), 64'd4);

    // 3: full + pop: first cycle only pops, next does push+pop
    cyc(0, 0, 1, 32'd16, 32'hE3A00018, 1);
    chk("pop_only", 64'(count), 64'd3);
    cyc(0, 0, 1, 32'd16, 32'hE3A00018, 1);
    chk("push_pop", 64'(count), 64'd3);
    chk("head_8",   64'(pc_out), 64'd8);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
    chk("drained", 64'(pop_valid), 64'd0);

    // 4: continuous push+pop across pointer wrap
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 32'(4*i), 32'hA000 + 32'(i), 1);
    cyc(0, 0, 0, 0, 0, 1);

    // 5: flush with push and pop pending
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'(4*i), 32'hB000 + 32'(i), 0);
    cyc(0, 1, 1, 32'd12, 32'hB003, 1);
    chk("flush_empty", 64'(pc_out), 64'd0);
    cyc(0, 0, 1, 32'h40, 32'hC0DE, 0);
    chk("post_flush_head", 64'(pc_out), 64'h40);

    // 6: reset mid-operation with a push in progress
    cyc(0, 0, 1, 32'h44, 32'hC0DF, 0);
    cyc(1, 0, 1, 32'h48, 32'hC0E0, 1);
    chk("rst_mid", 64'(count), 64'd0);
    cyc(0, 0, 1, 32'h80, 32'hD00D, 0);
    chk("post_rst_head", 64'(instruction_out), 64'hD00D);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 9) < 7), $urandom, $urandom,
          ($urandom_range(0, 9) < 6));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
